// File: rtl/cat_pkg.sv
// -----------------------------------------------------------------------------
// cat_pkg
// Shared types and default constants for the countdown actuator timer.
//   cat_state_e        : controller state encoding
//   *_DFLT localparams : default tick divider, seconds ceiling, fire length
//                        and blocked-sensor timeout
// -----------------------------------------------------------------------------
package cat_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FIRE  = 3'd3,
    FAULT = 3'd4
  } cat_state_e;

  localparam int TICK_DIV_DFLT      = 50;
  localparam int SEC_MAX_DFLT       = 59;
  localparam int FIRE_CYCLES_DFLT   = 512;
  localparam int BLOCK_TIMEOUT_DFLT = 1024;

endpackage

// File: rtl/countdown_actuator_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_actuator_timer_if
// Bundles the user/set path and the display/motor path of the timer.
//   master : drives set_time, set_sec, set_min, auto_reload, pause, sensor,
//            fault_clr; observes count_sec, count_min, actuator_en, expired,
//            fault
//   slave  : the timer itself (mirror directions)
// -----------------------------------------------------------------------------
interface countdown_actuator_timer_if #(
  parameter int SEC_W = 6,
  parameter int MIN_W = 6
);

  logic             set_time;
  logic [SEC_W-1:0] set_sec;
  logic [MIN_W-1:0] set_min;
  logic             auto_reload;
  logic             pause;
  logic             sensor;
  logic             fault_clr;
  logic [SEC_W-1:0] count_sec;
  logic [MIN_W-1:0] count_min;
  logic             actuator_en;
  logic             expired;
  logic             fault;

  modport master (
    output set_time, set_sec, set_min, auto_reload, pause, sensor, fault_clr,
    input  count_sec, count_min, actuator_en, expired, fault
  );

  modport slave (
    input  set_time, set_sec, set_min, auto_reload, pause, sensor, fault_clr,
    output count_sec, count_min, actuator_en, expired, fault
  );

endinterface

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides enabled clock cycles down to a one-second tick.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count this cycle
//   clr        : return to phase 0 (wins over en)
//   tick       : one-cycle pulse on every DIV-th enabled cycle
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  // Phase counter: wraps to zero on the terminal cycle, holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/countdown_actuator_timer.sv
// -----------------------------------------------------------------------------
// countdown_actuator_timer
// min:sec countdown that drives an actuator for FIRE_CYCLES cycles on expiry,
// with pause, one-shot/auto-reload and a blocked-sensor fault.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of countdown_actuator_timer_if (set inputs, mode
//                controls, sensor, fault clear; counts, actuator_en,
//                expired strobe, fault flag)
// -----------------------------------------------------------------------------
module countdown_actuator_timer
  import cat_pkg::*;
#(
  parameter int TICK_DIV      = TICK_DIV_DFLT,
  parameter int SEC_W         = 6,
  parameter int MIN_W         = 6,
  parameter int SEC_MAX       = SEC_MAX_DFLT,
  parameter int FIRE_CYCLES   = FIRE_CYCLES_DFLT,
  parameter int BLOCK_TIMEOUT = BLOCK_TIMEOUT_DFLT
) (
  input logic                       clk,
  input logic                       rst_n,
  countdown_actuator_timer_if.slave bus
);

  localparam int FIRE_W = (FIRE_CYCLES > 1) ? $clog2(FIRE_CYCLES) : 1;
  localparam int BLK_W  = (BLOCK_TIMEOUT > 1) ? $clog2(BLOCK_TIMEOUT) : 1;
  localparam logic [SEC_W-1:0]  SEC_MAX_V = SEC_W'(SEC_MAX);
  localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(FIRE_CYCLES - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLOCK_TIMEOUT - 1);

  cat_state_e       state_q;
  logic [SEC_W-1:0] sec_q, pre_sec_q;
  logic [MIN_W-1:0] min_q, pre_min_q;
  logic [FIRE_W-1:0] fire_cnt_q;
  logic [BLK_W-1:0]  blk_cnt_q;
  logic             expired_q;
  logic             fault_q;

  logic [SEC_W-1:0] load_sec_d, tick_sec_d;
  logic [MIN_W-1:0] load_min_d, tick_min_d;
  logic             load_nz;
  logic             tick_expires;
  logic             set_forces_load;
  logic             presc_en, presc_clr, tick;

  // set_time overrides every state except FAULT.
  assign set_forces_load = bus.set_time && (state_q != FAULT);

  // The prescaler only runs in RUN; anywhere else it sits at phase 0 so a
  // fresh RUN entry always waits a full second before the first tick.
  assign presc_en  = (state_q == RUN) && !bus.pause;
  assign presc_clr = (state_q != RUN) || bus.set_time;

  tick_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  // Preset capture values and the count after one tick (borrow on 0 sec).
  always_comb begin
    load_sec_d = (bus.set_sec > SEC_MAX_V) ? SEC_MAX_V : bus.set_sec;
    load_min_d = bus.set_min;
    load_nz    = (load_sec_d != '0) || (load_min_d != '0);
    tick_sec_d = sec_q;
    tick_min_d = min_q;
    if (sec_q != '0) begin
      tick_sec_d = sec_q - SEC_W'(1);
    end else if (min_q != '0) begin
      tick_sec_d = SEC_MAX_V;
      tick_min_d = min_q - MIN_W'(1);
    end else begin
      tick_sec_d = sec_q;
      tick_min_d = min_q;
    end
    // Only a tick that actually moves the count onto 0:00 expires.
    tick_expires = (tick_sec_d == '0) && (tick_min_d == '0) &&
                   ((sec_q != '0) || (min_q != '0));
  end

  // Controller FSM with counts, fire/block counters and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sec_q      <= '0;
      min_q      <= '0;
      pre_sec_q  <= '0;
      pre_min_q  <= '0;
      fire_cnt_q <= '0;
      blk_cnt_q  <= '0;
      expired_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      fault_q   <= 1'b0;
      if (set_forces_load && (state_q != LOAD)) begin
        state_q    <= LOAD;
        fire_cnt_q <= '0;
        blk_cnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= IDLE;
          end
          LOAD: begin
            sec_q     <= load_sec_d;
            min_q     <= load_min_d;
            pre_sec_q <= load_sec_d;
            pre_min_q <= load_min_d;
            if (bus.set_time) begin
              state_q <= LOAD;
            end else begin
              state_q <= load_nz ? RUN : IDLE;
            end
          end
          RUN: begin
            if (tick) begin
              sec_q <= tick_sec_d;
              min_q <= tick_min_d;
              if (tick_expires) begin
                expired_q  <= 1'b1;
                state_q    <= FIRE;
                fire_cnt_q <= '0;
                blk_cnt_q  <= '0;
              end
            end
          end
          FIRE: begin
            if (!bus.sensor) begin
              blk_cnt_q <= '0;
              if (fire_cnt_q == FIRE_LAST) begin
                fire_cnt_q <= '0;
                if (bus.auto_reload) begin
                  state_q <= RUN;
                  sec_q   <= pre_sec_q;
                  min_q   <= pre_min_q;
                end else begin
                  state_q <= IDLE;
                  sec_q   <= '0;
                  min_q   <= '0;
                end
              end else begin
                fire_cnt_q <= fire_cnt_q + FIRE_W'(1);
              end
            end else if (blk_cnt_q == BLK_LAST) begin
              blk_cnt_q <= '0;
              state_q   <= FAULT;
              fault_q   <= 1'b1;
            end else begin
              blk_cnt_q <= blk_cnt_q + BLK_W'(1);
            end
          end
          FAULT: begin
            if (bus.fault_clr) begin
              state_q <= IDLE;
              sec_q   <= '0;
              min_q   <= '0;
            end else begin
              fault_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Actuator drops in the same cycle the sensor reports an obstruction.
  assign bus.actuator_en = (state_q == FIRE) && !bus.sensor;
  assign bus.count_sec   = sec_q;
  assign bus.count_min   = min_q;
  assign bus.expired     = expired_q;
  assign bus.fault       = fault_q;

endmodule

// File: doc/countdown_actuator_timer.md
Name: countdown_actuator_timer

Overview:
Parametrised min:sec countdown timer that drives an actuator for a fixed number of cycles when the count expires. It is the successor of the single-mode dispenser timer. New features: configurable tick divider and widths, pause, one-shot vs auto-reload mode, an `expired` strobe, and a blocked-sensor timeout fault. Sits between the user set inputs / 7-seg display path and the motor driver.

Parameters:
TICK_DIV, 50, clk cycles per one-second tick (>=2)
SEC_W, 6, width of seconds fields
MIN_W, 6, width of minutes fields
SEC_MAX, 59, max seconds value; also the borrow reload value
FIRE_CYCLES, 512, number of clk cycles the actuator is driven per expiry
BLOCK_TIMEOUT, 1024, consecutive sensor-blocked FIRE cycles that cause a fault

Ports:
clk  in  1  system clock; single clock domain
rst_n  in  1  asynchronous active-low reset
set_time  in  1  level; high = load mode
set_sec  in  SEC_W  seconds preset
set_min  in  MIN_W  minutes preset
auto_reload  in  1  1 = reload preset after fire; 0 = one-shot
pause  in  1  freezes countdown in RUN
sensor  in  1  1 = obstruction; actuator is inhibited while high
fault_clr  in  1  clears FAULT
count_sec  out  SEC_W  current seconds
count_min  out  MIN_W  current minutes
actuator_en  out  1  motor drive request
expired  out  1  one-cycle strobe on reaching 0:00
fault  out  1  high in FAULT

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count_sec=0, count_min=0.
  - Prescaler, fire counter, block counter and latched preset all cleared.
  - expired=0, fault=0.
- States: IDLE, LOAD, RUN, FIRE, FAULT.
- set_time=1 takes priority over all other inputs in IDLE, RUN and FIRE. In those states it forces LOAD next cycle and clears the prescaler and fire counter. It is ignored in FAULT.
- IDLE:
  - Counts hold.
  - actuator_en=0.
- LOAD:
  - Every cycle: count_sec <= min(set_sec, SEC_MAX); count_min <= set_min. The preset latch is updated with the same values.
  - On set_time=0: go to RUN if the latched preset is non-zero, else IDLE.
- RUN:
  - The prescaler advances each cycle with pause=0 and holds when pause=1.
  - Terminal tick = prescaler at TICK_DIV-1; the prescaler wraps to 0 on it.
  - On a terminal tick:
    - if sec>0: sec-1;
    - else if min>0: sec=SEC_MAX and min-1 (borrow happens only on a tick, never immediately).
  - When a tick produces 0:00: expired=1 for that single cycle, next state FIRE.
- FIRE:
  - actuator_en = (state==FIRE) && !sensor. This is a combinational decode, so the actuator drops in the same cycle the sensor rises.
  - sensor=0:
    - fire counter +1; block counter cleared.
    - When fire counter reaches FIRE_CYCLES-1, exactly FIRE_CYCLES actuator cycles have elapsed, and the next state is:
      - auto_reload=1: RUN, counts loaded from the preset latch, prescaler 0.
      - auto_reload=0: IDLE with counts 0:00.
  - sensor=1:
    - fire counter holds; block counter +1.
    - When the block counter reaches BLOCK_TIMEOUT-1, the next state is FAULT.
- FAULT:
  - actuator_en=0, fault=1, counts hold.
  - fault_clr=1: go to IDLE with counts 0:00 and fault=0 next cycle.
- Widths and wrap:
  - Prescaler and fire counter are sized with $clog2 of their limit.
  - Counters never underflow; 0:00 is never decremented.
- Reset asserted mid-FIRE: actuator_en drops immediately (asynchronous), all state is cleared.
- set_time and an expiring tick in the same cycle: LOAD wins and expired stays 0.

Decomposition:
- Package `cat_pkg`: state enum (IDLE, LOAD, RUN, FIRE, FAULT) plus default constants for TICK_DIV, SEC_MAX, FIRE_CYCLES and BLOCK_TIMEOUT.
- One sub-module, `tick_prescaler`:
  - parameter DIV;
  - inputs clk, rst_n, en, clr;
  - output tick, a one-cycle pulse every DIV enabled cycles.
- The FSM and the count/fire/block counters stay in the top module.

Test Plan:
(Sim parameters: TICK_DIV=4, FIRE_CYCLES=8, BLOCK_TIMEOUT=6.)
1. Reset release, then set 0:02 with auto_reload=0 and set_time low -> 0:01 after 4 cycles, 0:00 after 8 with expired pulsed once; actuator_en high for exactly 8 cycles; then IDLE at 0:00.
2. Set 1:00 -> stays 1:00 for 3 cycles, 0:59 on the first tick (no immediate borrow). set_sec=63 -> count_sec=59. Preset 0:00 on set_time fall -> IDLE, no expired.
3. FIRE with sensor high for 3 cycles mid-pulse -> actuator_en low for those same cycles; total actuator-high cycles still 8.
4. FIRE with sensor held high 6 cycles -> fault=1, actuator_en=0; set_time ignored; fault_clr -> IDLE at 0:00, fault=0.
5. auto_reload=1 preset 0:01 -> after 8 fire cycles counts back to 0:01 in RUN; pause held 10 cycles in RUN -> counts and expiry delayed by exactly 10 cycles.
6. rst_n low during FIRE and set_time raised during RUN -> all outputs 0 immediately on reset; set_time causes LOAD next cycle with no expired pulse.
